// File: rtl/tlb_pkg.sv
// Shared TLB types and constants: widths, PTE bit positions, walker states,
// the fill-entry layout consumed by the TLB sets, and the PTE address helper.
package tlb_pkg;

  localparam int VA_W   = 64;
  localparam int PA_W   = 56;
  localparam int PPN_W  = 44;
  localparam int PCID_W = 12;
  localparam int LEVELS = 3;
  localparam int VPN_W  = 9 * LEVELS;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_FILL,
    ST_FAULT
  } walk_state_t;

  typedef struct packed {
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
    logic [PCID_W-1:0] pcid;
    logic [1:0]        level;
  } tlb_fill_t;

  // Address of the PTE for one level: table base plus 8-byte index, wrapping at PA_W.
  function automatic logic [PA_W-1:0] pte_addr(input logic [PPN_W-1:0] base,
                                               input logic [VPN_W-1:0] vpn,
                                               input logic [1:0]       lvl);
    logic [8:0] idx;
    case (lvl)
      2'd2:    idx = vpn[26:18];
      2'd1:    idx = vpn[17:9];
      default: idx = vpn[8:0];
    endcase
    return PA_W'({base, 12'b0}) + {{(PA_W-12){1'b0}}, idx, 3'b000};
  endfunction

endpackage

// File: rtl/tlb_walk_fill_if.sv
// Miss, PTE memory and TLB fill signals of the walker; master is the walker side.
interface tlb_walk_fill_if;
  import tlb_pkg::*;

  logic [PPN_W-1:0]  ptbr;
  logic              miss_valid;
  logic              miss_ready;
  logic [VA_W-1:0]   miss_vaddr;
  logic [PCID_W-1:0] miss_pcid;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [PA_W-1:0]   mem_req_addr;
  logic              mem_resp_valid;
  logic [63:0]       mem_resp_data;
  logic              fill_valid;
  logic [VPN_W-1:0]  fill_vpn;
  logic [PPN_W-1:0]  fill_ppn;
  logic [PCID_W-1:0] fill_pcid;
  logic [1:0]        fill_level;
  logic              fault;

  modport master (
    input  ptbr, miss_valid, miss_vaddr, miss_pcid,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr,
           fill_valid, fill_vpn, fill_ppn, fill_pcid, fill_level, fault
  );

  modport slave (
    output ptbr, miss_valid, miss_vaddr, miss_pcid,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr,
           fill_valid, fill_vpn, fill_ppn, fill_pcid, fill_level, fault
  );

endinterface

// File: rtl/tlb_pte_decode.sv
// Combinational PTE classifier for one walk level: leaf detection and all
// fault causes (invalid, reserved W-only, misaligned superpage, pointer at level 0).
module tlb_pte_decode
  import tlb_pkg::*;
(
  input  logic [63:0]      pte,
  input  logic [1:0]       lvl,
  output logic             is_leaf,
  output logic             is_fault,
  output logic [PPN_W-1:0] ppn
);

  logic        invalid;
  logic        misaligned;
  logic [17:0] low_mask;
  logic        unused_bits;

  assign ppn         = pte[PTE_PPN_LSB +: PPN_W];
  assign invalid     = !pte[PTE_V] || (pte[PTE_W] && !pte[PTE_R]);
  assign is_leaf     = pte[PTE_R] || pte[PTE_X];
  assign unused_bits = ^{pte[63:54], pte[9:4]};

  // A superpage leaf must have the PPN bits it replaces by VPN bits cleared.
  always_comb begin
    case (lvl)
      2'd2:    low_mask = 18'h3FFFF;
      2'd1:    low_mask = 18'h001FF;
      default: low_mask = 18'h00000;
    endcase
  end

  assign misaligned = |(ppn[17:0] & low_mask);
  assign is_fault   = invalid || (is_leaf && misaligned) || (!is_leaf && lvl == 2'd0);

endmodule

// File: rtl/tlb_walk_fill.sv
// Three-level page-table walker that refills the TLB after a miss.
// Optional TLB_WALK_PERF_EN adds saturating walk/fault counters.
module tlb_walk_fill
  import tlb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  tlb_walk_fill_if.master bus
`ifdef TLB_WALK_PERF_EN
  ,
  output logic [31:0] perf_walks,
  output logic [31:0] perf_faults
`endif
);

  walk_state_t       state;
  logic [VPN_W-1:0]  vpn;
  logic [PCID_W-1:0] pcid;
  logic [1:0]        lvl;
  logic              req_valid;
  logic [PA_W-1:0]   req_addr;
  tlb_fill_t         fill;
  logic              fill_pulse;
  logic              fault_pulse;
  logic              is_leaf;
  logic              is_fault;
  logic [PPN_W-1:0]  pte_ppn;
  logic              unused_vaddr;

  assign unused_vaddr = ^{bus.miss_vaddr[VA_W-1:39], bus.miss_vaddr[11:0]};

  tlb_pte_decode u_decode (
    .pte      (bus.mem_resp_data),
    .lvl      (lvl),
    .is_leaf  (is_leaf),
    .is_fault (is_fault),
    .ppn      (pte_ppn)
  );

  // Request address is computed on entry to REQ so it stays fixed under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      vpn         <= '0;
      pcid        <= '0;
      lvl         <= 2'd2;
      req_valid   <= 1'b0;
      req_addr    <= '0;
      fill        <= '0;
      fill_pulse  <= 1'b0;
      fault_pulse <= 1'b0;
    end else begin
      fill_pulse  <= 1'b0;
      fault_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.miss_valid) begin
            vpn       <= bus.miss_vaddr[38:12];
            pcid      <= bus.miss_pcid;
            lvl       <= 2'd2;
            req_valid <= 1'b1;
            req_addr  <= pte_addr(bus.ptbr, bus.miss_vaddr[38:12], 2'd2);
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_req_ready) begin
            req_valid <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.mem_resp_valid) begin
            if (is_fault) begin
              fault_pulse <= 1'b1;
              state       <= ST_FAULT;
            end else if (is_leaf) begin
              fill_pulse <= 1'b1;
              fill       <= '{vpn: vpn, ppn: pte_ppn, pcid: pcid, level: lvl};
              state      <= ST_FILL;
            end else begin
              lvl       <= lvl - 2'd1;
              req_valid <= 1'b1;
              req_addr  <= pte_addr(pte_ppn, vpn, lvl - 2'd1);
              state     <= ST_REQ;
            end
          end
        end
        ST_FILL, ST_FAULT: state <= ST_IDLE;
        default:           state <= ST_IDLE;
      endcase
    end
  end

  assign bus.miss_ready    = (state == ST_IDLE);
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = req_addr;
  assign bus.fill_valid    = fill_pulse;
  assign bus.fill_vpn      = fill.vpn;
  assign bus.fill_ppn      = fill.ppn;
  assign bus.fill_pcid     = fill.pcid;
  assign bus.fill_level    = fill.level;
  assign bus.fault         = fault_pulse;

`ifdef TLB_WALK_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_walks  <= '0;
      perf_faults <= '0;
    end else begin
      if ((state == ST_FILL || state == ST_FAULT) && perf_walks != 32'hFFFF_FFFF)
        perf_walks <= perf_walks + 32'd1;
      if (state == ST_FAULT && perf_faults != 32'hFFFF_FFFF)
        perf_faults <= perf_faults + 32'd1;
    end
  end
`endif

endmodule
